cat_cmd_uart_tx: RTL and testbench
==================================

Name: cat_cmd_uart_tx

Overview:
- UART command transmitter: the peer end of the badge's cat-status command decoder.
- Accepts abstract cat commands and encodes them into the single-byte ASCII protocol:
  - 'A'+idx clears cat idx.
  - 'a'+idx sets cat idx.
  - '`' (0x60) sets all cats.
- Buffers encoded bytes in a small FIFO and serializes them as 8N1 UART frames on tx.
- Drives a remote badge's interconnect rx line, or a bench/host link.

Parameters:
- CLK_FREQ, 103_340_000: system clock frequency in Hz.
- BAUD, 115_200: line rate in bit/s.
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW = 8 bytes.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command this cycle.
- cmd_op, input, 2: 00 clear cat (shoot), 01 set cat (revive), 10 set all, 11 reserved.
- cmd_idx, input, 3: cat index 0..7; ignored for op 10/11.
- tx, output, 1: UART serial out; idles high.
- busy, output, 1: high while a frame is in flight or the FIFO is non-empty.
- fifo_count, output, FIFO_AW+1: bytes currently queued (0..8).
- drop_err, output, 1: one-cycle pulse when a reserved op is accepted.

Behaviour:
- Decided: one clock (clk); reset_n is asynchronous and active-low.
- Reset (async assert, sync release) forces:
  - tx=1, busy=0, fifo_count=0, drop_err=0.
  - FSM to IDLE, baud counter to 0.
  - cmd_ready=1 from the first cycle after release.
- Baud divider:
  - DIV = (CLK_FREQ + BAUD/2) / BAUD, integer (rounded to nearest).
  - Every bit period is exactly DIV clk cycles.
  - Counter runs 0..DIV-1 and restarts on each bit boundary.
- Encoding (registered into the FIFO on accept):
  - op00 -> 8'h41 + idx.
  - op01 -> 8'h61 + idx.
  - op10 -> 8'h60.
  - op11 -> not enqueued; drop_err=1 for the following cycle.
- Handshake:
  - Accept when cmd_valid && cmd_ready.
  - cmd_ready = (fifo_count != 8), computed from registered state. A pop in the same cycle does not admit a push when full.
  - cmd_op and cmd_idx are sampled only on accept.
- FIFO:
  - Circular with FIFO_AW-bit pointers; pointers wrap 7->0.
  - Simultaneous push and pop when non-empty leaves fifo_count unchanged.
  - A push to an empty FIFO is not visible to the FSM until the next cycle (no bypass).
- FSM states and transitions:
  - IDLE: tx=1. If FIFO non-empty, pop the head byte into the shift register -> START.
  - START: tx=0 for DIV cycles -> DATA.
  - DATA: 8 bits, LSB first, DIV cycles each; 3-bit bit counter -> STOP after bit 7.
  - STOP: tx=1 for DIV cycles. On the last cycle, if the FIFO is non-empty, pop -> START; else -> IDLE.
- Timing:
  - Back-to-back frames have no idle gap; one frame is exactly 10*DIV cycles.
  - Latency: command accepted at edge N with FIFO empty and FSM IDLE -> pop at edge N+1 -> tx falls at edge N+2.
- tx is driven from a register (glitch-free).
- busy = (state != IDLE) || (fifo_count != 0).
- Reset mid-frame:
  - tx returns high immediately (async).
  - FIFO is flushed; the partial frame is abandoned and never resumed.
- Inputs are ignored while reset_n=0.
- cmd_idx is always 3 bits wide, so there is no out-of-range index case.

Test Plan:
(Bench uses CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10.)
- Reset check: assert reset_n=0 then release -> tx=1, cmd_ready=1, busy=0, fifo_count=0, drop_err=0.
- Single shoot command, op=00 idx=3, accepted at edge N:
  - tx=0 from edge N+2 for 10 cycles.
  - Data bits 0,0,1,0,0,0,1,0 (byte 0x44 'D'), 10 cycles each.
  - Stop bit high for 10 cycles; busy falls after the stop bit.
  - Total frame 100 cycles.
- Encoding sweep:
  - op01 idx7 -> 0x68.
  - op10 idx5 -> 0x60.
  - op00 idx0 -> 0x41.
  - Bench UART receiver decodes exactly these bytes in order.
- Reserved op, op=11:
  - drop_err pulses for exactly 1 cycle; fifo_count unchanged.
  - No frame on tx; cmd_ready stays 1.
- Full/back-pressure: hold cmd_valid with 12 consecutive op00 commands, idx=0..7 then 0..3:
  - fifo_count saturates at 8 and cmd_ready drops.
  - Stalled commands are accepted as frames complete.
  - tx carries 12 contiguous frames, 1200 cycles total, no idle gap, order preserved.
- Reset mid-frame:
  - Pull reset_n low during data bit 4 of the first of 3 queued frames -> tx=1 immediately, fifo_count=0.
  - After release: no further frames, busy=0, and a new command transmits normally.

Source files
------------

// File: rtl/cat_cmd_uart_tx.sv
// Cat command encoder feeding an 8-byte FIFO and an 8N1 UART serializer.
// Commands become single ASCII bytes ('A'+idx clear, 'a'+idx set, '`' set all).
module cat_cmd_uart_tx #(
    parameter int unsigned CLK_FREQ = 103_340_000,
    parameter int unsigned BAUD     = 115_200,
    parameter int unsigned FIFO_AW  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [2:0]         cmd_idx,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               drop_err
);

    localparam int unsigned DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int unsigned CW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam logic [CW-1:0]    DIV_LAST = CW'(DIV - 1);
    localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [7:0]           r_mem [DEPTH];
    logic [FIFO_AW-1:0]   r_wr_ptr;
    logic [FIFO_AW-1:0]   r_rd_ptr;
    logic [FIFO_AW:0]     r_count;
    logic [CW-1:0]        r_baud;
    logic [2:0]           r_bit;
    logic [7:0]           r_shift;
    logic                 r_tx;
    logic                 r_drop;

    logic                 w_accept;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_tick;
    logic                 w_tx_next;
    logic [7:0]           w_enc;

    assign cmd_ready  = (r_count != FULL);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_push     = w_accept && (cmd_op != 2'b11);
    assign w_empty    = (r_count == '0);
    assign w_tick     = (r_baud == DIV_LAST);

    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE) || !w_empty;
    assign fifo_count = r_count;
    assign drop_err   = r_drop;

    always_comb begin
        w_enc = 8'h60;
        case (cmd_op)
            2'b00:   w_enc = 8'h41 + {5'd0, cmd_idx};
            2'b01:   w_enc = 8'h61 + {5'd0, cmd_idx};
            default: w_enc = 8'h60;
        endcase
    end

    // Storage has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_accept && (cmd_op == 2'b11);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!w_empty) w_state_next = S_START;
            S_START: if (w_tick) w_state_next = S_DATA;
            S_DATA:  if (w_tick && (r_bit == 3'd7)) w_state_next = S_STOP;
            S_STOP:  if (w_tick) w_state_next = w_empty ? S_IDLE : S_START;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = 1'b0;
        w_tx_next = 1'b1;
        case (r_state)
            S_IDLE:  w_pop = !w_empty;
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = r_shift[0];
            S_STOP:  w_pop = w_tick && !w_empty;
            default: w_tx_next = 1'b1;
        endcase
    end

    // tx is registered from the state decode, so the line lags the FSM by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
            if (w_pop) begin
                r_baud  <= '0;
                r_bit   <= '0;
                r_shift <= r_mem[r_rd_ptr];
            end else begin
                if (r_state == S_IDLE || w_tick) begin
                    r_baud <= '0;
                end else begin
                    r_baud <= r_baud + CW'(1);
                end
                if (r_state == S_DATA && w_tick) begin
                    r_bit   <= r_bit + 3'd1;
                    r_shift <= {1'b0, r_shift[7:1]};
                end
            end
        end
    end

endmodule

// File: tb/tb_cat_cmd_uart_tx.sv
// Randomized and directed bench for cat_cmd_uart_tx with a behavioural
// UART receiver and an expected-byte queue as the reference.
module tb_cat_cmd_uart_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'd0;
    logic [2:0] cmd_idx = 3'd0;
    logic       cmd_ready;
    logic       tx;
    logic       busy;
    logic [3:0] fifo_count;
    logic       drop_err;

    cat_cmd_uart_tx #(
        .CLK_FREQ (1_000_000),
        .BAUD     (100_000),
        .FIFO_AW  (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_idx    (cmd_idx),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         starts_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] enc(input logic [1:0] op, input logic [2:0] idx);
        case (op)
            2'd0:    return 8'h41 + 8'(idx);
            2'd1:    return 8'h61 + 8'(idx);
            default: return 8'h60;
        endcase
    endfunction

    // Receiver: a frame is 100 cycles from the first low sample; every cycle is
    // compared with the ideal waveform of the expected byte.
    bit         rx_active = 1'b0;
    bit         rx_have;
    int         rx_ph;
    int         rx_wave_err;
    int         slot;
    int         frames_started = 0;
    logic       eb;
    logic [7:0] rx_byte;
    logic [7:0] rx_exp;

    always @(negedge clk) begin
        if (!reset_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active   = 1'b1;
                rx_ph       = 0;
                rx_byte     = 8'h00;
                rx_wave_err = 0;
                rx_have     = (exp_q.size() != 0);
                rx_exp      = rx_have ? exp_q.pop_front() : 8'h00;
                starts_q.push_back(cyc);
                frames_started++;
            end
        end else begin
            rx_ph++;
        end
        if (rx_active && reset_n) begin
            slot = rx_ph / 10;
            if (slot == 0)      eb = 1'b0;
            else if (slot == 9) eb = 1'b1;
            else                eb = rx_exp[slot-1];
            if (tx !== eb) rx_wave_err++;
            if (slot >= 1 && slot <= 8 && (rx_ph % 10) == 5) rx_byte[slot-1] = tx;
            if (rx_ph == 99) begin
                check("rx_pending", 32'(rx_have), 1);
                check("rx_byte", rx_byte, rx_exp);
                check("rx_wave", rx_wave_err, 0);
                rx_log.push_back(rx_byte);
                rx_active = 1'b0;
            end
        end
    end

    bit mon_en = 1'b0;
    bit saw_full = 1'b0;
    int max_cnt = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
            if (!cmd_ready) saw_full = 1'b1;
        end
    end

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [1:0] op, input logic [2:0] idx, output int acc);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(n < 3000), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        if (op != 2'd3) exp_q.push_back(enc(op, idx));
        @(negedge clk);
        check("drop_err", 32'(drop_err), 32'(op == 2'd3));
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((busy || rx_active || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(n < budget), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int f0;
        int n;
        logic [1:0] rop;
        logic [2:0] ridx;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_drop", 32'(drop_err), 0);

        // Single shoot command, op00 idx3 -> 'D'
        starts_q.delete();
        rx_log.delete();
        send(2'd0, 3'd3, acc);
        check("single_count", 32'(fifo_count), 1);
        @(negedge clk);
        check("single_popped", 32'(fifo_count), 0);
        while (cyc < acc + 100) @(negedge clk);
        check("single_busy_stop", 32'(busy), 1);
        while (cyc < acc + 102) @(negedge clk);
        check("single_busy_done", 32'(busy), 0);
        wait_idle(500);
        check("single_frames", starts_q.size(), 1);
        check("single_latency", starts_q[0] - acc, 2);
        check("single_byte", rx_log[0], 8'h44);

        // Encoding sweep
        rx_log.delete();
        send(2'd1, 3'd7, acc);
        send(2'd2, 3'd5, acc);
        send(2'd0, 3'd0, acc);
        wait_idle(1000);
        check("sweep_n", rx_log.size(), 3);
        check("sweep_0", rx_log[0], 8'h68);
        check("sweep_1", rx_log[1], 8'h60);
        check("sweep_2", rx_log[2], 8'h41);

        // Reserved op
        f0 = frames_started;
        send(2'd3, 3'd2, acc);
        check("rsv_count", 32'(fifo_count), 0);
        check("rsv_ready", 32'(cmd_ready), 1);
        @(negedge clk);
        check("rsv_drop_end", 32'(drop_err), 0);
        repeat (150) @(negedge clk);
        check("rsv_no_frame", frames_started - f0, 0);
        check("rsv_tx", 32'(tx), 1);

        // Back-pressure: 12 held commands
        rx_log.delete();
        starts_q.delete();
        max_cnt  = 0;
        saw_full = 1'b0;
        mon_en   = 1'b1;
        for (int i = 0; i < 12; i++) send(2'd0, 3'(i % 8), acc);
        wait_idle(3000);
        mon_en = 1'b0;
        check("bp_max_count", max_cnt, 8);
        check("bp_not_ready", 32'(saw_full), 1);
        check("bp_frames", rx_log.size(), 12);
        for (int i = 0; i < 12; i++) check("bp_order", rx_log[i], enc(2'd0, 3'(i % 8)));
        for (int i = 1; i < 12; i++) check("bp_gap", starts_q[i] - starts_q[i-1], 100);
        check("bp_total", starts_q[11] + 100 - starts_q[0], 1200);

        // Reset during data bit 4 of the first of three queued frames
        starts_q.delete();
        f0 = frames_started;
        send(2'd0, 3'd1, acc);
        send(2'd1, 3'd2, acc);
        send(2'd2, 3'd0, acc);
        n = 0;
        while (frames_started == f0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_start_wait", 32'(n < 500), 1);
        while (cyc < starts_q[0] + 55) @(negedge clk);
        check("mid_pre_count", 32'(fifo_count), 2);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_tx", 32'(tx), 1);
        check("mid_count", 32'(fifo_count), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        f0 = frames_started;
        repeat (300) @(negedge clk);
        check("mid_no_resume", frames_started - f0, 0);
        check("mid_busy", 32'(busy), 0);
        check("mid_idle_tx", 32'(tx), 1);
        rx_log.delete();
        send(2'd1, 3'd4, acc);
        wait_idle(500);
        check("mid_new_n", rx_log.size(), 1);
        check("mid_new_byte", rx_log[0], enc(2'd1, 3'd4));

        // Randomized traffic, including reserved ops and bursts that fill the FIFO
        for (int i = 0; i < 30; i++) begin
            rop  = 2'($urandom_range(0, 3));
            ridx = 3'($urandom_range(0, 7));
            send(rop, ridx, acc);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(50, 250) : $urandom_range(0, 4);
            repeat (n) @(negedge clk);
        end
        wait_idle(5000);
        check("rand_drained", exp_q.size(), 0);
        check("rand_count", 32'(fifo_count), 0);
        check("rand_tx", 32'(tx), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
